// File: rtl/axi_stream_pwm_pattern.sv
// Stream master feeding a PWM stage with duty codes in one of four patterns:
// triangle, sawtooth up, sawtooth down or constant. Each code repeats in_repeat+1 times.
module axi_stream_pwm_pattern #(
  parameter int WIDTH        = 5,
  parameter int REPEAT_WIDTH = 4
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic                    in_enable,
  input  logic [1:0]              in_mode,
  input  logic [WIDTH-1:0]        in_level,
  input  logic [REPEAT_WIDTH-1:0] in_repeat,
  input  logic                    in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_period_done,
  output logic                    out_busy
);

  localparam logic [WIDTH-1:0] MAXV    = {WIDTH{1'b1}};
  localparam logic [1:0]       M_TRI   = 2'd0;
  localparam logic [1:0]       M_UP    = 2'd1;
  localparam logic [1:0]       M_DN    = 2'd2;
  localparam logic [1:0]       M_CONST = 2'd3;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        code_q, code_d;
  logic [REPEAT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic                    dir_down_q, dir_down_d;
  logic [1:0]              mode_q, mode_d;
  logic [WIDTH-1:0]        level_q, level_d;
  logic [REPEAT_WIDTH-1:0] repeat_q, repeat_d;
  logic                    period_done_q, period_done_d;

  logic                    xfer;
  logic [WIDTH-1:0]        code_inc;
  logic [WIDTH-1:0]        code_dec;
  logic                    last_code;

  function automatic logic [WIDTH-1:0] start_code(input logic [1:0] mode,
                                                  input logic [WIDTH-1:0] level);
    case (mode)
      M_DN:    start_code = MAXV;
      M_CONST: start_code = level;
      default: start_code = '0;
    endcase
  endfunction

  assign xfer     = (state_q == SEND) && in_ready;
  assign code_inc = code_q + 1'b1;
  assign code_dec = code_q - 1'b1;

  always_comb begin
    last_code = 1'b0;
    case (mode_q)
      M_UP:    last_code = (code_q == MAXV);
      M_DN:    last_code = (code_q == '0);
      M_TRI:   last_code = dir_down_q && (code_q == WIDTH'(1));
      default: last_code = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    rep_cnt_d     = rep_cnt_q;
    dir_down_d    = dir_down_q;
    mode_d        = mode_q;
    level_d       = level_q;
    repeat_d      = repeat_q;
    period_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_enable) begin
          state_d    = SEND;
          mode_d     = in_mode;
          level_d    = in_level;
          repeat_d   = in_repeat;
          code_d     = start_code(in_mode, in_level);
          dir_down_d = 1'b0;
          rep_cnt_d  = '0;
        end
      end
      default: begin
        if (xfer) begin
          if (rep_cnt_q < repeat_q) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end else begin
            rep_cnt_d     = '0;
            period_done_d = last_code;
            if (!in_enable) begin
              state_d    = IDLE;
              code_d     = '0;
              dir_down_d = 1'b0;
            end else begin
              // Config is only re-latched here so a code never changes mid-repeat.
              mode_d   = in_mode;
              level_d  = in_level;
              repeat_d = in_repeat;
              if (in_mode != mode_q) begin
                code_d     = start_code(in_mode, in_level);
                dir_down_d = 1'b0;
              end else begin
                case (mode_q)
                  M_UP:    code_d = code_inc;
                  M_DN:    code_d = code_dec;
                  M_CONST: code_d = in_level;
                  default: begin
                    if (!dir_down_q) begin
                      code_d = code_inc;
                      if (code_inc == MAXV) dir_down_d = 1'b1;
                    end else begin
                      code_d = code_dec;
                      if (code_dec == '0) dir_down_d = 1'b0;
                    end
                  end
                endcase
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q       <= IDLE;
      code_q        <= '0;
      rep_cnt_q     <= '0;
      dir_down_q    <= 1'b0;
      mode_q        <= '0;
      level_q       <= '0;
      repeat_q      <= '0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      rep_cnt_q     <= rep_cnt_d;
      dir_down_q    <= dir_down_d;
      mode_q        <= mode_d;
      level_q       <= level_d;
      repeat_q      <= repeat_d;
      period_done_q <= period_done_d;
    end
  end

  assign out_valid       = (state_q == SEND);
  assign out_busy        = (state_q != IDLE);
  assign out_data        = code_q;
  assign out_period_done = period_done_q;

endmodule

// File: tb/tb_axi_stream_pwm_pattern.sv
// Bench for axi_stream_pwm_pattern: index-based pattern model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_axi_stream_pwm_pattern;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rdy = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [4:0] level = 5'd0;
  logic [3:0] rep = 4'd0;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_period_done;
  logic       out_busy;

  int total = 0;
  int bad = 0;

  axi_stream_pwm_pattern #(.WIDTH(5), .REPEAT_WIDTH(4)) dut (
    .in_clock(clk),
    .in_reset(rst),
    .in_enable(en),
    .in_mode(mode),
    .in_level(level),
    .in_repeat(rep),
    .in_ready(rdy),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_period_done(out_period_done),
    .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pattern position as a plain index into the ideal sequence.
  bit m_run = 1'b0;
  bit m_pd = 1'b0;
  int m_mode = 0, m_level = 0, m_rep = 0, m_idx = 0, m_cnt = 0;

  function automatic int exp_code(input int md, input int idx, input int lvl);
    int t;
    case (md)
      0: begin t = idx % 62; exp_code = (t <= 31) ? t : 62 - t; end
      1: exp_code = idx % 32;
      2: exp_code = 31 - (idx % 32);
      default: exp_code = lvl;
    endcase
  endfunction

  function automatic bit period_end(input int md, input int idx);
    case (md)
      0: period_end = ((idx % 62) == 61);
      1, 2: period_end = ((idx % 32) == 31);
      default: period_end = 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_pd = 1'b0;
      m_mode = 0; m_level = 0; m_rep = 0; m_idx = 0; m_cnt = 0;
    end else begin
      m_pd = 1'b0;
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1; m_mode = int'(mode); m_level = int'(level);
          m_rep = int'(rep); m_idx = 0; m_cnt = 0;
        end
      end else if (rdy) begin
        if (m_cnt < m_rep) begin
          m_cnt++;
        end else begin
          m_cnt = 0;
          m_pd = period_end(m_mode, m_idx);
          if (!en) begin
            m_run = 1'b0; m_idx = 0;
          end else begin
            if (int'(mode) != m_mode) m_idx = 0;
            else m_idx++;
            m_mode = int'(mode); m_level = int'(level); m_rep = int'(rep);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_valid", int'(out_valid), int'(m_run));
    chk("model_busy", int'(out_busy), int'(m_run));
    chk("model_pdone", int'(out_period_done), int'(m_pd));
    chk("model_data", int'(out_data), m_run ? exp_code(m_mode, m_idx, m_level) : 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic stop_idle();
    en = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (!out_valid) break;
    end
    chk("stop_timeout", int'(out_valid), 0);
  endtask

  int rec[$];
  int pd_cnt, n31, n0, nlow;

  initial begin
    // Reset with ready high
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_busy", int'(out_busy), 0);
    end

    // Saw up, repeat 0
    rst = 1'b0; en = 1'b1; mode = 2'd1; rep = 4'd0;
    tick(1);
    chk("saw_first_valid", int'(out_valid), 1);
    pd_cnt = 0;
    for (int k = 0; k < 34; k++) begin
      if (k < 33) chk("saw_code", int'(out_data), k % 32);
      if (out_period_done) begin
        pd_cnt++;
        chk("saw_pd_pos", k, 32);
      end
      tick(1);
    end
    chk("saw_pd_count", pd_cnt, 1);

    // Triangle, repeat 0
    stop_idle();
    mode = 2'd0; rep = 4'd0; en = 1'b1;
    tick(1);
    pd_cnt = 0; n31 = 0; n0 = 0;
    for (int k = 0; k < 70; k++) begin
      if (k < 62 && out_data == 5'd31) n31++;
      if (k < 62 && out_data == 5'd0) n0++;
      if (k == 31) chk("tri_k31", int'(out_data), 31);
      if (k == 32) chk("tri_k32", int'(out_data), 30);
      if (k == 61) chk("tri_k61", int'(out_data), 1);
      if (k == 62) chk("tri_k62", int'(out_data), 0);
      if (k == 63) chk("tri_k63", int'(out_data), 1);
      if (out_period_done) begin
        pd_cnt++;
        chk("tri_pd_pos", k, 62);
      end
      tick(1);
    end
    chk("tri_single_peak", n31, 1);
    chk("tri_single_zero", n0, 1);
    chk("tri_pd_count", pd_cnt, 1);

    // Saw up, repeat 2, ready one cycle in 32
    stop_idle();
    mode = 2'd1; rep = 4'd2; rdy = 1'b0; en = 1'b1;
    tick(1);
    rec.delete(); nlow = 0;
    for (int c = 0; c < 7 * 32; c++) begin
      rdy = ((c % 32) == 31);
      if (!out_valid) nlow++;
      if (out_valid && rdy) rec.push_back(int'(out_data));
      tick(1);
    end
    chk("stall_xfers", rec.size(), 7);
    chk("stall_valid_low", nlow, 0);
    if (rec.size() == 7) begin
      chk("stall_x0", rec[0], 0); chk("stall_x2", rec[2], 0);
      chk("stall_x3", rec[3], 1); chk("stall_x5", rec[5], 1);
      chk("stall_x6", rec[6], 2);
    end

    // Constant, level change mid-repeat
    stop_idle();
    mode = 2'd3; level = 5'd7; rep = 4'd3; en = 1'b1;
    tick(1);
    rec.delete(); pd_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) level = 5'd20;
      if (out_period_done) pd_cnt++;
      if (out_valid && rdy) rec.push_back(int'(out_data));
      tick(1);
    end
    chk("const_xfers", rec.size(), 8);
    if (rec.size() == 8) begin
      chk("const_x3", rec[3], 7);
      chk("const_x4", rec[4], 20);
      chk("const_x7", rec[7], 20);
    end
    chk("const_pd_count", pd_cnt, 1);

    // Enable dropped during second repeat of code 5
    stop_idle();
    mode = 2'd1; rep = 4'd3; en = 1'b1;
    tick(1);
    for (int k = 0; k < 24; k++) begin
      if (k == 20) chk("drop_code5", int'(out_data), 5);
      if (k == 23) chk("drop_last5", int'(out_data), 5);
      if (k == 21) en = 1'b0;
      tick(1);
    end
    chk("drop_valid", int'(out_valid), 0);
    chk("drop_busy", int'(out_busy), 0);
    en = 1'b1;
    tick(1);
    chk("reen_valid", int'(out_valid), 1);
    chk("reen_data", int'(out_data), 0);

    // Reset during a stalled transfer
    rdy = 1'b0;
    tick(2);
    chk("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    tick(1);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_busy", int'(out_busy), 0);
    rst = 1'b0; mode = 2'd2; rep = 4'd0; rdy = 1'b1; en = 1'b1;
    tick(1);
    chk("sawdn_start", int'(out_data), 31);
    tick(1);
    chk("sawdn_next", int'(out_data), 30);
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_stream_pwm_pattern.md
Name: axi_stream_pwm_pattern

Overview:
- AXI-stream-style master that generates a sequence of duty-cycle codes for the downstream 5-bit PWM stage. It sits directly upstream of that stage, with out_valid/out_data driving its valid/data inputs and in_ready taking its ready output.
- Produces triangle ("breathing"), sawtooth-up, sawtooth-down or constant patterns.
- Each code is emitted a programmable number of times, so the ramp speed is set in PWM periods.

Parameters:
- WIDTH, 5, width of the duty code. Max code MAXV = 2^WIDTH-1.
- REPEAT_WIDTH, 4, width of the per-code repeat setting.

Ports:
- in_clock  input  1  clock, all logic on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_enable  input  1  run request (level)
- in_mode  input  2  0=triangle, 1=saw up, 2=saw down, 3=constant
- in_level  input  WIDTH  code used in constant mode
- in_repeat  input  REPEAT_WIDTH  each code is transferred in_repeat+1 times
- in_ready  input  1  downstream ready
- out_valid  output  1  data valid
- out_data  output  WIDTH  duty code
- out_period_done  output  1  one-cycle pulse at end of a pattern period
- out_busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is in_clock, reset port is in_reset.
- Reset values: out_valid=0, out_data=0, out_period_done=0, out_busy=0, state=IDLE, rep_cnt=0, dir=up, all latched config=0.
- Handshake: a transfer occurs on a cycle where out_valid && in_ready.
  - Once out_valid is high, out_valid and out_data stay stable until the transfer.
  - out_valid never depends combinationally on in_ready.
- States:
  - IDLE: out_valid=0.
    - If in_enable=1: latch mode, level and repeat, load the start code, go to SEND. out_valid=1 on the next cycle (1-cycle latency from enable sampled high).
    - Start code: triangle=0 with dir=up; saw up=0; saw down=MAXV; constant=in_level.
  - SEND: out_valid=1.
    - On a transfer with rep_cnt < latched repeat: rep_cnt++, same code presented again, out_valid stays 1. Back-to-back transfers are allowed, one per cycle.
    - On a transfer with rep_cnt == latched repeat: rep_cnt=0, advance the code (below), re-latch mode, level and repeat from the inputs (config changes take effect only at code boundaries).
    - If in_enable=0 at that boundary transfer: go to IDLE, out_valid=0 next cycle.
    - in_enable falling mid-code never drops out_valid. All repeats of the current code complete first, then the block goes to IDLE.
- Code advance:
  - Saw up: v+1, MAXV wraps to 0.
  - Saw down: v-1, 0 wraps to MAXV.
  - Triangle: if dir=up, v+1, and on reaching MAXV set dir=down. If dir=down, v-1, and on reaching 0 set dir=up. Peaks are not duplicated: sequence 0,1,…,MAXV,MAXV-1,…,1,0,1,…
  - Constant: next code = in_level.
  - Mode change at a boundary: the new mode starts from its start code, and triangle dir resets to up. Same mode: continue from the current code.
- out_period_done: pulses high the cycle after the final-repeat transfer of:
  - MAXV in saw up
  - 0 in saw down
  - 1 on the triangle down slope
  - any code in constant mode
- Returning to IDLE clears dir, rep_cnt and the current code. A later enable restarts from the start code.
- Reset mid-transfer: all outputs return to reset values on the next edge regardless of in_ready.
- All arithmetic wraps modulo 2^WIDTH. No saturation logic beyond the wrap rules above.

Test Plan:
- Reset with in_ready=1: out_valid=0, out_data=0, out_busy=0 for all reset cycles. Enable=1, mode=1, repeat=0 → out_valid=1 next cycle, codes 0,1,…,31,0. out_period_done pulses once after code 31.
- Mode=0, repeat=0, in_ready=1 for 70 cycles → codes 0..31,30..1,0,1,… with a single 31 and a single 0 at the turnarounds. One out_period_done after the first down-slope 1.
- Mode=1, repeat=2, in_ready asserted 1 cycle per 32 (PWM-like) → each code seen on 3 transfers. out_data stable and out_valid held high through all 31-cycle stalls.
- Mode=3, level=7, then level changed to 20 mid-repeat with repeat=3 → four transfers of 7, then 20. Change applies only at the boundary.
- Enable dropped during the 2nd of 4 repeats of code 5 → the remaining repeats of 5 complete, out_valid=0 the cycle after, out_busy=0. Re-enable restarts at code 0.
- Reset asserted while out_valid=1 and in_ready=0 → next cycle out_valid=0, out_data=0. After reset, mode=2 starts at 31.
